// File: rtl/hbm_pkg.sv
// Shared HBM command-port types and constants.
// Used by the port arbiter and the controller glue.
package hbm_pkg;

  localparam int HBM_ADDR_W = 32;
  localparam int HBM_DATA_W = 512;

  localparam logic HBM_CMD_READ  = 1'b0;
  localparam logic HBM_CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } arb_state_t;

  function automatic int rr_wrap(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/hbm_port_arbiter_rr_picker.sv
// Round-robin search: first set request after ptr_i,
// wrapping, with ptr_i itself checked last.
module rr_picker
  import hbm_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // scan far-to-near so the nearest hit is assigned last
    for (int i = N; i >= 1; i--) begin
      logic [PW-1:0] j;
      j = PW'(rr_wrap(int'(ptr_i), i, N));
      if (req_i[j]) begin
        idx_o = j;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbm_port_arbiter.sv
// Shares one HBM controller command port among NUM_PORTS
// requesters, round-robin, with a completion watchdog.
module hbm_port_arbiter
  import hbm_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = HBM_ADDR_W,
  parameter int DATA_W    = HBM_DATA_W,
  parameter int TIMEOUT   = 1023
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS-1:0]          req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_error,
  output logic [ADDR_W-1:0]             ctl_addr,
  output logic [DATA_W-1:0]             ctl_wdata,
  output logic                          ctl_wr_en,
  output logic                          ctl_rd_en,
  input  logic                          ctl_ready,
  input  logic                          ctl_error,
  input  logic [DATA_W-1:0]             ctl_rdata,
  output logic                          busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NUM_PORTS - 1);

  arb_state_t state_q, state_d;

  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        port_q, port_d;
  logic                 write_q, write_d;
  logic [CW-1:0]        wd_q, wd_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rd_buf_q, rd_buf_d;
  logic [NUM_PORTS-1:0] req_ready_q, req_ready_d;
  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_error_q, rsp_error_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 busy_q, busy_d;

  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic          fin;

  rr_picker #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    port_d      = port_q;
    write_d     = write_q;
    wd_d        = wd_q;
    err_d       = err_q;
    rd_buf_d    = rd_buf_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_en_d     = wr_en_q;
    rd_en_d     = rd_en_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_error_d = 1'b0;
    fin         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctl_ready && pick_vld) begin
          state_d  = ISSUE;
          rr_d     = pick_idx;
          port_d   = pick_idx;
          write_d  = req_write[pick_idx];
          addr_d   = req_addr[pick_idx*ADDR_W +: ADDR_W];
          wdata_d  = req_wdata[pick_idx*DATA_W +: DATA_W];
          wr_en_d  = (req_write[pick_idx] == HBM_CMD_WRITE);
          rd_en_d  = (req_write[pick_idx] == HBM_CMD_READ);
          wd_d     = '0;
          err_d    = 1'b0;
          req_ready_d[pick_idx] = 1'b1;
        end
      end
      ISSUE, BUSY: begin
        wd_d = wd_q + CW'(1);
        // completion beats a timeout landing on the same cycle
        if (state_q == BUSY && ctl_ready) begin
          fin = 1'b1;
        end else if (wd_q == WD_LAST) begin
          wr_en_d = 1'b0;
          rd_en_d = 1'b0;
          err_d   = 1'b1;
          state_d = DRAIN;
        end else if (state_q == BUSY) begin
          rd_buf_d = ctl_rdata;
        end else if (!ctl_ready) begin
          state_d = BUSY;
        end
      end
      DRAIN: begin
        if (ctl_ready) fin = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      state_d             = RESP;
      wr_en_d             = 1'b0;
      rd_en_d             = 1'b0;
      rsp_valid_d[port_q] = 1'b1;
      rsp_error_d         = ctl_error | err_q;
      rsp_rdata_d         = (write_q || err_q) ? '0 : rd_buf_q;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_q        <= PTR_RST;
      port_q      <= '0;
      write_q     <= 1'b0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      rd_buf_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      write_q     <= write_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      rd_buf_q    <= rd_buf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign ctl_addr  = addr_q;
  assign ctl_wdata = wdata_q;
  assign ctl_wr_en = wr_en_q;
  assign ctl_rd_en = rd_en_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_hbm_port_arbiter.sv
// Scoreboard bench for hbm_port_arbiter with a
// behavioural controller that answers on the falling edge.
module tb_hbm_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset_n;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_error;
  logic [AW-1:0]   ctl_addr;
  logic [DW-1:0]   ctl_wdata;
  logic            ctl_wr_en;
  logic            ctl_rd_en;
  logic            ctl_ready;
  logic            ctl_error;
  logic [DW-1:0]   ctl_rdata;
  logic            busy;

  always #5 clk = ~clk;

  hbm_port_arbiter #(
    .NUM_PORTS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_wr_en (ctl_wr_en),
    .ctl_rd_en (ctl_rd_en),
    .ctl_ready (ctl_ready),
    .ctl_error (ctl_error),
    .ctl_rdata (ctl_rdata),
    .busy      (busy)
  );

  typedef struct {
    logic [N-1:0]  port;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   glog[$];

  int n_chk = 0;
  int n_fail = 0;

  int mrr, gcnt, rsp_cnt, cyc;
  int en_run, en_last, last_gnt_cyc, rdy_rise_cyc;
  int last_g, left;
  int pcnt [N];
  logic [N-1:0] last_gnt_vec;

  bit hang, hold_off, exp_err, exp_abort;
  int lat;

  logic [AW-1:0] cur_a;
  logic [DW-1:0] cur_wd;
  logic          cur_w;

  task automatic chk(
    input string         tag,
    input logic [DW-1:0] obs,
    input logic [DW-1:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
    return {16{a ^ 32'h0000_1000}} ^ {64{8'hA5}};
  endfunction

  function automatic logic [DW-1:0] wd_pat(input int p, input logic [AW-1:0] a);
    return {16{a + 32'(p)}} ^ {64{8'h3C}};
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 1; i <= N; i++) begin
      int j;
      j = (ptr + i) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // monitor, scoreboard and controller model share one ordered loop
  initial begin
    exp_t e;
    ctl_ready = 1'b1;
    ctl_rdata = '0;
    mrr = N - 1;
    gcnt = 0; rsp_cnt = 0; cyc = 0;
    en_run = 0; en_last = 0; left = 0;
    last_gnt_cyc = 0; rdy_rise_cyc = 0; last_g = 0;
    last_gnt_vec = '0;
    for (int i = 0; i < N; i++) pcnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        mrr = N - 1;
        left = 0;
        ctl_ready = 1'b1;
        en_run = 0;
        sb.delete();
      end else begin
        if (req_ready != '0) begin
          int g;
          g = 0;
          for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
          chk("gnt_onehot", $countones(req_ready), 1);
          chk("gnt_rr", g, rr_pick(req_valid, mrr));
          mrr = g;
          gcnt++;
          glog.push_back(g);
          last_gnt_cyc = cyc;
          last_gnt_vec = req_ready;
          last_g = g;
          cur_a  = req_addr[g*AW +: AW];
          cur_w  = req_write[g];
          cur_wd = req_wdata[g*DW +: DW];
          e.port  = N'(1) << g;
          e.err   = exp_err | exp_abort;
          e.rdata = (cur_w || exp_abort) ? '0 : rd_pat(cur_a);
          sb.push_back(e);
        end
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("rsp_port", rsp_valid, e.port);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_error", rsp_error, e.err);
          end
          rsp_cnt++;
          for (int i = 0; i < N; i++) if (rsp_valid[i]) pcnt[i]++;
        end
        if (ctl_wr_en || ctl_rd_en) begin
          en_run++;
        end else if (en_run > 0) begin
          en_last = en_run;
          en_run = 0;
        end
        if (left > 0) begin
          if (!hang) begin
            left--;
            if (left == 1) ctl_rdata = rd_pat(ctl_addr);
            if (left == 0) begin
              ctl_ready = 1'b1;
              rdy_rise_cyc = cyc;
            end
          end
        end else if (hold_off) begin
          ctl_ready = 1'b0;
        end else if (ctl_ready && (ctl_wr_en || ctl_rd_en)) begin
          chk("ctl_addr", ctl_addr, cur_a);
          chk("ctl_wr_en", ctl_wr_en, cur_w);
          chk("ctl_rd_en", ctl_rd_en, !cur_w);
          if (cur_w) chk("ctl_wdata", ctl_wdata, cur_wd);
          ctl_ready = 1'b0;
          left = lat;
          ctl_rdata = (lat == 1) ? rd_pat(ctl_addr) : ~rd_pat(ctl_addr);
        end else begin
          if (!ctl_ready) rdy_rise_cyc = cyc;
          ctl_ready = 1'b1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a);
    req_addr[p*AW +: AW]  = a;
    req_write[p]          = w;
    req_wdata[p*DW +: DW] = wd_pat(p, a);
    req_valid[p]          = 1'b1;
  endtask

  task automatic wait_gnt(input int n);
    int b;
    b = 0;
    while (gcnt < n && b < 300) begin
      step(1);
      b++;
    end
    chk("wait_gnt", gcnt >= n, 1);
  endtask

  task automatic wait_rsp(input int n);
    int b;
    b = 0;
    while (rsp_cnt < n && b < 300) begin
      step(1);
      b++;
    end
    chk("wait_rsp", rsp_cnt >= n, 1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    int b0, r0, g0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    ctl_error = 1'b0;
    hang = 0; hold_off = 0; exp_err = 0; exp_abort = 0;
    lat = 2;
    step(3);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_wr_en", ctl_wr_en, 0);
    chk("rst_rd_en", ctl_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctl_addr", ctl_addr, 0);
    chk("rst_ctl_wdata", ctl_wdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    step(1);

    // single read, port 2
    lat = 6;
    g0 = gcnt; r0 = rsp_cnt;
    set_req(2, 1'b0, 32'h0000_1000);
    wait_gnt(g0 + 1);
    req_valid[2] = 1'b0;
    chk("t1_req_ready", last_gnt_vec, 4'b0100);
    wait_rsp(r0 + 1);
    chk("t1_en_cycles", en_last, 7);
    step(2);

    // continuous writes from reset
    do_reset();
    lat = 2;
    b0 = glog.size(); g0 = gcnt; r0 = rsp_cnt;
    for (int i = 0; i < N; i++) pcnt[i] = 0;
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 32'h0000_2000 + 32'(p * 64));
    wait_gnt(g0 + 8);
    req_valid = '0;
    wait_rsp(r0 + 8);
    for (int k = 0; k < 8; k++) chk("t2_order", glog[b0 + k], k % N);
    for (int p = 0; p < N; p++) chk("t2_per_port", pcnt[p], 2);
    step(2);

    // watchdog: controller never returns ready
    lat = 3;
    hang = 1;
    exp_abort = 1;
    g0 = gcnt; r0 = rsp_cnt;
    set_req(1, 1'b0, 32'h0000_3000);
    wait_gnt(g0 + 1);
    req_valid[1] = 1'b0;
    step(20);
    chk("t3_drain_busy", busy, 1);
    chk("t3_en_off", ctl_wr_en | ctl_rd_en, 0);
    chk("t3_no_rsp", rsp_cnt, r0);
    chk("t3_en_cycles", en_last, TO);
    hang = 0;
    wait_rsp(r0 + 1);
    exp_abort = 0;
    step(2);

    // controller error during a port 1 write
    lat = 6;
    exp_err = 1;
    g0 = gcnt; r0 = rsp_cnt;
    set_req(1, 1'b1, 32'h0000_4000);
    wait_gnt(g0 + 1);
    req_valid[1] = 1'b0;
    step(2);
    ctl_error = 1'b1;
    wait_rsp(r0 + 1);
    ctl_error = 1'b0;
    exp_err = 0;
    step(1);
    set_req(0, 1'b0, 32'h0000_4040);
    wait_gnt(g0 + 2);
    req_valid[0] = 1'b0;
    chk("t4_next_gnt", last_gnt_vec, 4'b0001);
    wait_rsp(r0 + 2);
    step(2);

    // no grant while controller is not ready
    lat = 2;
    hold_off = 1;
    step(2);
    g0 = gcnt; r0 = rsp_cnt;
    set_req(3, 1'b0, 32'h0000_5000);
    step(5);
    chk("t5_held", gcnt, g0);
    hold_off = 0;
    wait_gnt(g0 + 1);
    req_valid[3] = 1'b0;
    chk("t5_req_ready", last_gnt_vec, 4'b1000);
    chk("t5_gnt_lat", last_gnt_cyc - rdy_rise_cyc, 1);
    wait_rsp(r0 + 1);
    step(2);

    // reset in the middle of a busy transaction
    lat = 20;
    g0 = gcnt;
    set_req(2, 1'b0, 32'h0000_6000);
    wait_gnt(g0 + 1);
    req_valid[2] = 1'b0;
    step(4);
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_en", ctl_rd_en, 1);
    reset_n = 1'b0;
    #1;
    chk("t6_wr_en", ctl_wr_en, 0);
    chk("t6_rd_en", ctl_rd_en, 0);
    chk("t6_busy", busy, 0);
    step(3);
    r0 = rsp_cnt;
    reset_n = 1'b1;
    lat = 2;
    g0 = gcnt;
    set_req(0, 1'b0, 32'h0000_7000);
    set_req(1, 1'b1, 32'h0000_7040);
    set_req(3, 1'b0, 32'h0000_70C0);
    for (int k = 1; k <= 3; k++) begin
      wait_gnt(g0 + k);
      req_valid[last_g] = 1'b0;
      if (k == 1) chk("t6_first_gnt", last_gnt_vec, 4'b0001);
    end
    wait_rsp(r0 + 3);
    step(4);
    chk("t6_rsp_count", rsp_cnt, r0 + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hbm_port_arbiter.md
Name: hbm_port_arbiter

Overview:
- Round-robin arbiter that shares one HBM controller command port among NUM_PORTS requesters, such as DMA engines and a CPU bridge.
- Accepts one request at a time and latches it.
- Drives the controller's wr_en/rd_en/addr/data_in and tracks completion via the controller's ready level.
- Returns read data and error status to the originating port; a timeout watchdog recovers from a stalled controller.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 512, data width
TIMEOUT, 1023, max cycles from issue to completion before error abort (counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_PORTS  per-port request; held until req_ready
req_write  in  NUM_PORTS  1=write, 0=read
req_addr  in  NUM_PORTS*ADDR_W  per-port address, port i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_PORTS*DATA_W  per-port write data
req_ready  out  NUM_PORTS  one-hot accept pulse
rsp_valid  out  NUM_PORTS  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_error  out  1  error flag, valid with rsp_valid
ctl_addr  out  ADDR_W  to controller addr
ctl_wdata  out  DATA_W  to controller data_in
ctl_wr_en  out  1  to controller wr_en
ctl_rd_en  out  1  to controller rd_en
ctl_ready  in  1  controller idle/ready level
ctl_error  in  1  controller error (sticky)
ctl_rdata  in  DATA_W  controller data_out
busy  out  1  arbiter not in IDLE

Behaviour:
- Reset: state IDLE, rr_ptr=NUM_PORTS-1. All outputs 0; latched addr/wdata 0.
- FSM states: IDLE, ISSUE, BUSY, RESP, DRAIN.
- IDLE:
  - If ctl_ready=1 and any req_valid, grant the first set bit searching from rr_ptr+1 upward with wrap.
  - Pulse req_ready[g] for exactly that cycle; latch write/addr/wdata/port; set rr_ptr=g; go to ISSUE.
  - If ctl_ready=0, grant nothing.
- ISSUE:
  - Drive ctl_addr/ctl_wdata from the latch; ctl_wr_en=write, ctl_rd_en=~write, both registered.
  - When ctl_ready=0 is sampled, go to BUSY.
- BUSY:
  - Keep the enable asserted. Every cycle, capture ctl_rdata into rd_buf.
  - When ctl_ready=1 is sampled, drop the enable and go to RESP.
  - rd_buf therefore holds the last busy-cycle sample.
- RESP:
  - One cycle: rsp_valid[port]=1, rsp_rdata=rd_buf (0 for writes), rsp_error=ctl_error.
  - Return to IDLE; a new grant is possible in the next cycle.
- Watchdog:
  - Counter clears on entry to ISSUE and increments in ISSUE/BUSY.
  - On reaching TIMEOUT: deassert enables, set err_latched, go to DRAIN.
- DRAIN: wait for ctl_ready=1, then go to RESP with rsp_error=1 and rsp_rdata=0.
- Latency: minimum grant-to-response is 1 (ISSUE) + controller busy cycles + 1 (RESP).
- Fairness: a port continuously requesting waits at most NUM_PORTS-1 transactions.
- Simultaneous events:
  - A new req_valid arriving during RESP is not granted until IDLE.
  - ctl_error rising during BUSY is not an abort; it is reported at RESP.
  - Timeout and ctl_ready=1 in the same cycle: completion wins, no error.
- req_valid dropping before grant is legal and causes no side effect. Request fields are ignored after accept.
- Reset mid-transaction:
  - All enables drop immediately (asynchronous).
  - No rsp_valid is emitted for the aborted request.
  - rr_ptr returns to NUM_PORTS-1.
- Outputs req_ready, rsp_valid, ctl_* and busy are registered.

Decomposition:
- Package hbm_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, BUSY, RESP, DRAIN);
  - HBM_ADDR_W=32 and HBM_DATA_W=512 constants;
  - HBM_CMD_READ/HBM_CMD_WRITE encodings shared with the controller.
- One sub-module, rr_picker: a combinational round-robin priority search taking req vector and rr_ptr and returning grant index plus valid.
- Watchdog counter and FSM stay in the top module.

Test Plan:
- Single read, port 2, addr 0x0000_1000: controller ready low 6 cycles, ctl_rdata=0xA5.. on last busy cycle -> req_ready=0100, rsp_valid=0100, rsp_rdata=0xA5.., rsp_error=0.
- All four ports request writes continuously from reset -> grant order 0,1,2,3,0; each port gets exactly one rsp_valid per four transactions.
- Controller never raises ready, TIMEOUT=15 -> enables drop 15 cycles after ISSUE entry; after ctl_ready returns, port rsp_valid with rsp_error=1 and rsp_rdata=0.
- ctl_error=1 during a port 1 write -> rsp_valid[1]=1 with rsp_error=1; next request is still granted normally.
- ctl_ready=0 at time of req_valid from port 3 -> no req_ready until ctl_ready=1; grant arrives the cycle after.
- reset_n asserted low mid-BUSY -> ctl_wr_en/ctl_rd_en=0 immediately, no rsp_valid; after release, port 0 wins the first arbitration.
